// File: rtl/beat_if.sv
// beat_if: narrow beat stream in, packed word stream out (up_*/down_*), plus flush/down_count under PACKER_FLUSH_EN
interface beat_if #(
  parameter int D_WIDTH = 6,
  parameter int BEATS   = 4
);
  logic [D_WIDTH-1:0]       up_data;
  logic                     up_valid;
  logic                     up_ready;
  logic [D_WIDTH*BEATS-1:0] down_data;
  logic                     down_valid;
  logic                     down_ready;
`ifdef PACKER_FLUSH_EN
  logic                     flush;
  logic [$clog2(BEATS):0]   down_count;
  modport master(output up_data, up_valid, down_ready, flush, input up_ready, down_data, down_valid, down_count);
  modport slave(input up_data, up_valid, down_ready, flush, output up_ready, down_data, down_valid, down_count);
`else
  modport master(output up_data, up_valid, down_ready, input up_ready, down_data, down_valid);
  modport slave(input up_data, up_valid, down_ready, output up_ready, down_data, down_valid);
`endif
endinterface

// File: rtl/beat_packer.sv
// beat_packer: packs BEATS D_WIDTH-bit beats into one registered word; ports clk, rst (sync active-low), b (beat_if.slave); PACKER_FLUSH_EN adds flush/down_count
module beat_packer #(
  parameter int D_WIDTH = 6,
  parameter int BEATS   = 4
) (
  input logic   clk,
  input logic   rst,
  beat_if.slave b
);
  localparam int W  = D_WIDTH * BEATS;
  localparam int CW = $clog2(BEATS);
  logic [W-D_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 fp;
  logic                 last;
  logic                 out_free;
  logic                 fire;
  logic                 flush_load;
  always_comb begin
    last       = cnt == CW'(BEATS - 1);
    out_free   = !b.down_valid || b.down_ready;
    b.up_ready = (!last || out_free) && !fp;
    fire       = b.up_valid && b.up_ready;
    flush_load = fp && out_free;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc          <= '0;
      cnt          <= '0;
      b.down_data  <= '0;
      b.down_valid <= 1'b0;
`ifdef PACKER_FLUSH_EN
      b.down_count <= '0;
`endif
    end else if (fire && last) begin
      b.down_data  <= {b.up_data, acc};
      b.down_valid <= 1'b1;
`ifdef PACKER_FLUSH_EN
      b.down_count <= (CW+1)'(BEATS);
`endif
      acc          <= '0;
      cnt          <= '0;
    end else if (flush_load) begin
      b.down_data  <= W'(acc);
      b.down_valid <= 1'b1;
`ifdef PACKER_FLUSH_EN
      b.down_count <= {1'b0, cnt};
`endif
      acc          <= '0;
      cnt          <= '0;
    end else begin
      if (b.down_ready) b.down_valid <= 1'b0;
      if (fire) begin
        acc[cnt*D_WIDTH +: D_WIDTH] <= b.up_data;
        cnt                         <= cnt + 1'b1;
      end
    end
  end
`ifdef PACKER_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst) fp <= 1'b0;
    else if (flush_load) fp <= 1'b0;
    else if (b.flush && (fire ? !last : cnt != '0)) fp <= 1'b1;
  end
`else
  assign fp = 1'b0;
`endif
endmodule

// File: tb/tb_beat_packer.sv
module tb_beat_packer;
  localparam int D = 6;
  localparam int B = 4;
  localparam int W = D * B;
  typedef struct {
    logic [W-1:0] d;
    int           n;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_i = 1'b0;
  int checks = 0;
  int errors = 0;
  item_t exp_q[$];
  logic [W-1:0] got[$];
  logic [D-1:0] pend[$];
  bit fpm = 0;
  bit prev_hold = 0;
  logic [W-1:0] prev_d;
  logic [W-1:0] w;
  item_t it;
  int dcount;
  int waits;
  int total_waits;
  always #5 clk = ~clk;
  beat_if #(.D_WIDTH(D), .BEATS(B)) bus();
  beat_packer #(.D_WIDTH(D), .BEATS(B)) dut(.clk(clk), .rst(rst), .b(bus));
`ifdef PACKER_FLUSH_EN
  assign bus.flush = flush_i;
  assign dcount = int'(bus.down_count);
`else
  assign dcount = B;
`endif
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  // reference model: queue of accepted beats, queue of words owed downstream
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      exp_q.delete();
      fpm = 0;
      prev_hold = 0;
    end else begin
      chk("up_ready", bus.up_ready, !(pend.size() == B - 1 && bus.down_valid && !bus.down_ready) && !fpm);
      if (prev_hold) begin
        chk("hold_valid", bus.down_valid, 1);
        chk("hold_data", bus.down_data, prev_d);
      end
      if (bus.down_valid && bus.down_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %h want none", bus.down_data);
        end else begin
          it = exp_q.pop_front();
          chk("word", bus.down_data, it.d);
`ifdef PACKER_FLUSH_EN
          chk("count", dcount, it.n);
`endif
        end
        got.push_back(bus.down_data);
      end
      prev_hold = bus.down_valid && !bus.down_ready;
      prev_d = bus.down_data;
      if (fpm && (!bus.down_valid || bus.down_ready)) fpm = 0;
      if (bus.up_valid && bus.up_ready) begin
        pend.push_back(bus.up_data);
        if (pend.size() == B) begin
          w = '0;
          for (int i = 0; i < B; i++) w[i*D +: D] = pend[i];
          exp_q.push_back('{w, B});
          pend.delete();
        end
      end
`ifdef PACKER_FLUSH_EN
      if (flush_i && pend.size() > 0) begin
        w = '0;
        for (int i = 0; i < pend.size(); i++) w[i*D +: D] = pend[i];
        exp_q.push_back('{w, pend.size()});
        pend.delete();
        fpm = 1;
      end
`endif
    end
  end
  task automatic send(input logic [D-1:0] d, output int nw);
    bus.up_valid = 1'b1;
    bus.up_data = d;
    nw = 0;
    forever begin
      @(negedge clk);
      if (bus.up_ready) break;
      nw++;
      if (nw > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got stalled want accepted");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.down_ready = 1'b1;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.down_valid, 0);
    chk("rst_data", bus.down_data, 0);
    chk("rst_ready", bus.up_ready, 1);
    idle(1);
    // basic pack
    got.delete();
    for (int i = 1; i <= 4; i++) send(D'(i), waits);
    @(negedge clk);
    chk("basic_valid", bus.down_valid, 1);
    chk("basic_data", bus.down_data, 24'h103081);
    idle(1);
    @(negedge clk);
    chk("basic_pulse", bus.down_valid, 0);
    idle(1);
    // streaming
    got.delete();
    total_waits = 0;
    for (int i = 0; i < 12; i++) begin
      send(D'(i), waits);
      total_waits += waits;
    end
    idle(2);
    chk("stream_stalls", total_waits, 0);
    chk("stream_words", got.size(), 3);
    if (got.size() == 3) begin
      chk("stream_w0", got[0], 24'h0C2040);
      chk("stream_w1", got[1], 24'h1C6144);
      chk("stream_w2", got[2], 24'h2CA248);
    end
    // backpressure
    got.delete();
    bus.down_ready = 1'b0;
    total_waits = 0;
    for (int i = 0; i < 7; i++) begin
      send(D'(i), waits);
      total_waits += waits;
    end
    chk("bp_accept7", total_waits, 0);
    bus.up_valid = 1'b1;
    bus.up_data = 6'd7;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", bus.up_ready, 0);
      chk("bp_hold", bus.down_data, 24'h0C2040);
    end
    @(posedge clk);
    #1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", bus.up_ready, 1);
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    @(negedge clk);
    chk("bp_w2_valid", bus.down_valid, 1);
    chk("bp_w2_data", bus.down_data, 24'h1C6144);
    idle(2);
    chk("bp_words", got.size(), 2);
    // reset mid-word
    send(6'd9, waits);
    send(6'd10, waits);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    got.delete();
    for (int i = 5; i <= 8; i++) send(D'(i), waits);
    @(negedge clk);
    chk("rst_mid_data", bus.down_data, 24'h207185);
    idle(2);
    chk("rst_mid_words", got.size(), 1);
`ifdef PACKER_FLUSH_EN
    // flush on idle cycle
    send(6'h3F, waits);
    send(6'h15, waits);
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_pend_ready", bus.up_ready, 0);
    chk("fl_pend_valid", bus.down_valid, 0);
    idle(1);
    @(negedge clk);
    chk("fl_valid", bus.down_valid, 1);
    chk("fl_data", bus.down_data, 24'h00057F);
    chk("fl_count", dcount, 2);
    chk("fl_ready", bus.up_ready, 1);
    idle(1);
    // flush with beat while output stalled
    bus.down_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(D'(i), waits);
    bus.up_valid = 1'b1;
    bus.up_data = 6'h2A;
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl2_accept", bus.up_ready, 1);
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("fl2_stall", bus.up_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    chk("fl2_loading", bus.up_ready, 0);
    idle(1);
    @(negedge clk);
    chk("fl2_valid", bus.down_valid, 1);
    chk("fl2_data", bus.down_data, 24'h00002A);
    chk("fl2_count", dcount, 1);
    chk("fl2_ready", bus.up_ready, 1);
`endif
    idle(4);
    chk("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
